// File: rtl/vga_pkg.sv
// Shared types, 1024x768@60 (65 MHz) timing constants and helpers for the VGA timing generator.
package vga_pkg;

  typedef logic [10:0] cnt_t;
  typedef logic [15:0] frame_cnt_t;
  typedef logic [11:0] rgb_t;

  localparam cnt_t HOR_TOTAL      = 11'd1344;
  localparam cnt_t HOR_ACTIVE     = 11'd1024;
  localparam cnt_t HOR_SYNC_START = 11'd1048;
  localparam cnt_t HOR_SYNC_END   = 11'd1184;

  localparam cnt_t VER_TOTAL      = 11'd806;
  localparam cnt_t VER_ACTIVE     = 11'd768;
  localparam cnt_t VER_SYNC_START = 11'd771;
  localparam cnt_t VER_SYNC_END   = 11'd777;

  localparam rgb_t RGB_BLACK = 12'h000;

  // Half-open window test [lo, hi).
  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing stream bundle: pixel position, sync/blank flags and pixel colour.
interface vga_if;
  import vga_pkg::*;

  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  rgb_t rgb;

  modport vga_out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport vga_in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with registered sync, blank and frame-end flags that are
// decoded from the next-state counters so every output lines up with hcount/vcount.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter cnt_t       H_TOTAL       = HOR_TOTAL,
  parameter cnt_t       H_ACTIVE      = HOR_ACTIVE,
  parameter cnt_t       H_SYNC_START  = HOR_SYNC_START,
  parameter cnt_t       H_SYNC_END    = HOR_SYNC_END,
  parameter cnt_t       V_TOTAL       = VER_TOTAL,
  parameter cnt_t       V_ACTIVE      = VER_ACTIVE,
  parameter cnt_t       V_SYNC_START  = VER_SYNC_START,
  parameter cnt_t       V_SYNC_END    = VER_SYNC_END,
  // Reset value of the frame counter; only non-zero for preloaded instances.
  parameter frame_cnt_t FRAME_CNT_RST = 16'd0
) (
  input  logic           clk,
  input  logic           rst,
  vga_if.vga_out         vga_out,
  output logic           frame_end,
  output frame_cnt_t     frame_cnt
);

  localparam cnt_t H_LAST = H_TOTAL - 11'd1;
  localparam cnt_t V_LAST = V_TOTAL - 11'd1;

  cnt_t       hcount_q, hcount_d;
  cnt_t       vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hblnk_q, hblnk_d;
  logic       vblnk_q, vblnk_d;
  logic       frame_end_q, frame_end_d;
  frame_cnt_t frame_cnt_q, frame_cnt_d;
  logic       h_wrap_s;
  logic       f_wrap_s;

  // Next position, frame counter and flags decoded from that next position.
  always_comb begin
    h_wrap_s    = (hcount_q == H_LAST);
    f_wrap_s    = h_wrap_s && (vcount_q == V_LAST);
    hcount_d    = hcount_q + 11'd1;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;

    if (h_wrap_s) begin
      hcount_d = 11'd0;
      if (f_wrap_s) begin
        vcount_d = 11'd0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end else begin
      vcount_d = vcount_q;
    end

    if (f_wrap_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    hblnk_d     = (hcount_d >= H_ACTIVE);
    vblnk_d     = (vcount_d >= V_ACTIVE);
    hsync_d     = in_window(hcount_d, H_SYNC_START, H_SYNC_END);
    vsync_d     = in_window(vcount_d, V_SYNC_START, V_SYNC_END);
    frame_end_d = (hcount_d == H_LAST) && (vcount_d == V_LAST);
  end

  // State registers; reset parks the stream at (0,0) with every flag low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= 11'd0;
      vcount_q    <= 11'd0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      frame_end_q <= 1'b0;
      frame_cnt_q <= FRAME_CNT_RST;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hblnk_q     <= hblnk_d;
      vblnk_q     <= vblnk_d;
      frame_end_q <= frame_end_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = RGB_BLACK;
  assign frame_end      = frame_end_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 clk  input  1  pixel clock (65 MHz, 1024x768@60); all state updates on its rising edge.
REQ-002 rst  input  1  reset; asynchronous and active-high.
REQ-003 vga_out  vga_if.vga_out  bundle  timing stream source: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0].
REQ-004 frame_end  output  1  one-cycle pulse on the last pixel of each frame.
REQ-005 frame_cnt  output  16  number of completed frames since reset.

Function
REQ-006 The block SHALL count the pixel position with hcount in 0..1343 and vcount in 0..805.
REQ-007 Each clock, hcount SHALL increment by 1.
  - At 1343, hcount SHALL wrap to 0 and vcount SHALL increment by 1.
REQ-008 When hcount=1343 and vcount=805, both counters SHALL wrap to 0 on the same edge.
REQ-009 hblnk SHALL be 1 exactly when hcount >= 1024.
REQ-010 hsync SHALL be 1 exactly when 1048 <= hcount < 1184 (active-high; board-level polarity is handled outside this block).
REQ-011 vblnk SHALL be 1 exactly when vcount >= 768.
REQ-012 vsync SHALL be 1 exactly when 771 <= vcount < 777.
REQ-013 hsync, vsync, hblnk and vblnk SHALL be registered and SHALL correspond to the hcount/vcount values presented in the same cycle (zero skew, no combinational output paths).
REQ-014 vga_out.rgb SHALL be constant 12'h000; downstream draw stages overlay content.
REQ-015 frame_end SHALL be 1 for exactly one cycle, in the cycle where outputs show hcount=1343 and vcount=805, and 0 otherwise.
REQ-016 frame_cnt SHALL increment by 1 on the edge where the counters wrap (1343,805)->(0,0).
  - frame_cnt SHALL wrap from 65535 to 0 without saturation.
REQ-017 Counter arithmetic SHALL be unsigned 11-bit.
  - Values outside the valid ranges are unreachable from reset and need no recovery logic.
REQ-018 Frame geometry SHALL be 1344 clocks per line and 806 lines per frame.
  - Each frame SHALL last exactly 1,083,264 clocks.

Reset
REQ-019 While rst=1, all outputs SHALL hold these values:
  - hcount=0, vcount=0
  - hsync=0, vsync=0, hblnk=0, vblnk=0
  - rgb=0
  - frame_end=0, frame_cnt=0
REQ-020 Reset SHALL take effect immediately on rst assertion, independent of clk, including mid-line and mid-frame.
REQ-021 The first rising edge after rst deasserts SHALL present hcount=1, vcount=0; position (0,0) is the cycle held during reset.
REQ-022 A reset asserted during frame_end SHALL clear frame_end immediately and SHALL NOT increment frame_cnt.

Structure
REQ-023 These timing constants SHALL live in vga_pkg and SHALL NOT be hard-coded in this module:
  - HOR_TOTAL=1344, HOR_ACTIVE=1024, HOR_SYNC_START=1048, HOR_SYNC_END=1184
  - VER_TOTAL=806, VER_ACTIVE=768, VER_SYNC_START=771, VER_SYNC_END=777
REQ-024 Sync and blank flags SHALL be computed from the next-state counter values and then registered, so they align with the counters.
REQ-025 The block SHALL be a single module with no sub-module; the two counters are too small to justify a separate counter block.

Verification
REQ-026 Reset check: assert rst mid-frame at hcount=500, vcount=300 -> all outputs 0 within the same cycle, without waiting for a clock edge; after release, hcount=1, 2, 3... on successive edges.
REQ-027 Horizontal edges: on line 0, monitor hblnk and hsync.
  - hblnk 0->1 when hcount goes 1023->1024.
  - hsync rises at 1048 and falls at 1184.
  - hcount wraps 1343->0 with vcount 0->1.
REQ-028 Vertical edges: monitor vblnk and vsync at line boundaries.
  - vblnk rises at vcount=768, hcount=0.
  - vsync is high for vcount 771..776, exactly 6 lines = 8064 clocks.
  - vblnk falls at wrap to vcount=0.
REQ-029 Frame end: run to (1343,805) -> frame_end=1 for that single cycle; next edge gives (0,0), frame_cnt=1, frame_end=0.
REQ-030 Long run: run 3 frames.
  - frame_cnt=3.
  - Consecutive frame_end pulses exactly 1,083,264 cycles apart.
  - Exactly 1024x768 cycles per frame with hblnk=0 and vblnk=0.
REQ-031 Counter wrap: force frame_cnt near its limit (via a long run or a bench-only preload), then complete one frame -> 65535->0 with no glitch on frame_end.
